// File: rtl/parity_frame_checker_if.sv
// parity_frame_checker_if
//   Beat-in / result-out bundle for the streaming parity checker.
//   Input stream : odd_mode, in_valid, in_ready, in_data, in_last, in_par
//   Result stream: out_valid, out_ready, out_parity, par_err, len_err, out_count
//   master = link side (drives beats, consumes results)
//   slave  = parity_frame_checker
interface parity_frame_checker_if #(
    parameter int WIDTH     = 4,
    parameter int MAX_WORDS = 8,
    localparam int CNT_W    = $clog2(MAX_WORDS + 1)
);
    logic             odd_mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_par;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic             par_err;
    logic             len_err;
    logic [CNT_W-1:0] out_count;

    modport master (
        output odd_mode, in_valid, in_data, in_last, in_par, out_ready,
        input  in_ready, out_valid, out_parity, par_err, len_err, out_count
    );

    modport slave (
        input  odd_mode, in_valid, in_data, in_last, in_par, out_ready,
        output in_ready, out_valid, out_parity, par_err, len_err, out_count
    );
endinterface

// File: rtl/parity_frame_checker.sv
// parity_frame_checker
//   XOR-accumulates every data bit of a multi-beat frame and reports the
//   frame parity (odd/even chosen on the first beat), a mismatch against the
//   received parity bit, and a length-overflow flag.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : parity_frame_checker_if.slave (beat input + result output streams)
module parity_frame_checker #(
    parameter int WIDTH     = 4,
    parameter int MAX_WORDS = 8,
    localparam int CNT_W    = $clog2(MAX_WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    parity_frame_checker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_t           state_q, state_d;
    logic             acc_q, mode_q, ovf_q;
    logic [CNT_W-1:0] cnt_q;

    logic             par_q, par_err_q, len_err_q;
    logic [CNT_W-1:0] count_q;

    logic [WIDTH-1:0] beat_data;
    logic             in_fire, out_fire, first_beat;
    logic             wp, acc_n, mode_eff, parity_n, at_max, len_n;
    logic [CNT_W-1:0] count_n;

    assign beat_data  = bus.in_data;
    assign in_fire    = bus.in_valid & bus.in_ready;
    assign out_fire   = bus.out_valid & bus.out_ready;
    assign first_beat = (state_q == IDLE);

    // The first beat starts a fresh accumulation and samples odd_mode
    // directly, so nothing left over in acc_q/mode_q can leak into it.
    assign wp       = ^beat_data;
    assign acc_n    = first_beat ? wp : (acc_q ^ wp);
    assign mode_eff = first_beat ? bus.odd_mode : mode_q;
    assign parity_n = acc_n ^ mode_eff;

    // A beat arriving with the counter already at MAX_WORDS is one too many.
    assign at_max  = !first_beat && (cnt_q == MAX_CNT);
    assign count_n = first_beat ? CNT_W'(1) : (at_max ? cnt_q : cnt_q + CNT_W'(1));
    assign len_n   = !first_beat && (ovf_q || at_max);

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred for state_d.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_fire) state_d = bus.in_last ? REPORT : ACCUM;
            ACCUM:   if (in_fire && bus.in_last) state_d = REPORT;
            REPORT:  if (out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        bus.in_ready  = 1'b1;
        bus.out_valid = 1'b0;
        if (state_q == REPORT) begin
            bus.in_ready  = 1'b0;
            bus.out_valid = 1'b1;
        end
    end

    // Frame accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= 1'b0;
            mode_q    <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
            len_err_q <= 1'b0;
            count_q   <= '0;
        end else if (in_fire) begin
            acc_q <= acc_n;
            cnt_q <= count_n;
            ovf_q <= len_n;
            if (first_beat) mode_q <= bus.odd_mode;
            if (bus.in_last) begin
                par_q     <= parity_n;
                par_err_q <= bus.in_par ^ parity_n;
                len_err_q <= len_n;
                count_q   <= count_n;
            end
        end else if (out_fire) begin
            acc_q <= 1'b0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end
    end

    assign bus.out_parity = par_q;
    assign bus.par_err    = par_err_q;
    assign bus.len_err    = len_err_q;
    assign bus.out_count  = count_q;
endmodule

// File: tb/tb_parity_frame_checker.sv
module tb_parity_frame_checker;
    localparam int WIDTH     = 4;
    localparam int MAX_WORDS = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    parity_frame_checker_if #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) bus ();

    parity_frame_checker #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] frame_q[$];

    typedef struct {
        logic [WIDTH-1:0] data;
        bit               odd;
        bit               par;
        bit               exp_parity;
        bit               exp_err;
    } vec_t;
    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic check_result(input string tag, input bit ep, input bit ee, input bit el, input int ec);
        check({tag, " out_valid"},  32'(bus.out_valid), 1);
        check({tag, " in_ready"},   32'(bus.in_ready), 0);
        check({tag, " out_parity"}, 32'(bus.out_parity), 32'(ep));
        check({tag, " par_err"},    32'(bus.par_err), 32'(ee));
        check({tag, " len_err"},    32'(bus.len_err), 32'(el));
        check({tag, " out_count"},  32'(bus.out_count), ec);
    endtask

    // Reference: parity is the ones-count of the whole frame, flipped in odd mode.
    task automatic model(input bit odd, input bit par, output bit ep, output bit ee,
                         output bit el, output int ec);
        int ones = 0;
        foreach (frame_q[i]) ones += $countones(frame_q[i]);
        ep = ((ones % 2) == 1) ^ odd;
        ee = par ^ ep;
        el = frame_q.size() > MAX_WORDS;
        ec = (frame_q.size() > MAX_WORDS) ? MAX_WORDS : frame_q.size();
    endtask

    // Sends frame_q, then checks and takes the result.
    // toggle: mid-frame odd_mode is the opposite of the frame's mode.
    task automatic run_frame(input string tag, input bit odd, input bit par, input int max_gap,
                             input bit toggle, input int bp, input bit ep, input bit ee,
                             input bit el, input int ec);
        int n = frame_q.size();
        for (int i = 0; i < n; i++) begin
            int gap;
            int w;
            gap = (max_gap > 0 && i > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 'x;
                bus.odd_mode = toggle ? ~odd : 1'($urandom);
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = frame_q[i];
            bus.in_last  = (i == n - 1);
            bus.in_par   = (i == n - 1) ? par : 1'($urandom);
            bus.odd_mode = (i == 0) ? odd : (toggle ? ~odd : 1'($urandom));
            w = 0;
            while (!bus.in_ready && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            if (!bus.in_ready) check({tag, " in_ready timeout"}, 32'(bus.in_ready), 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 'x;
        check_result(tag, ep, ee, el, ec);
        repeat (bp) begin
            @(posedge clk); #1;
            check_result({tag, " hold"}, ep, ee, el, ec);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, " taken out_valid"}, 32'(bus.out_valid), 0);
        check({tag, " taken in_ready"},  32'(bus.in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ep, ee, el;
        int ec;

        for (int v = 0; v < 16; v++) begin
            vecs[v].data       = WIDTH'(v);
            vecs[v].odd        = 1'b1;
            vecs[v].exp_parity = ($countones(v) % 2) == 0;
            vecs[v].par        = vecs[v].exp_parity;
            vecs[v].exp_err    = 1'b0;
        end

        bus.odd_mode  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_par    = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        check("rst in_ready",   32'(bus.in_ready), 1);
        check("rst out_valid",  32'(bus.out_valid), 0);
        check("rst out_parity", 32'(bus.out_parity), 0);
        check("rst par_err",    32'(bus.par_err), 0);
        check("rst len_err",    32'(bus.len_err), 0);
        check("rst out_count",  32'(bus.out_count), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-beat odd-mode sweep from the vector table.
        for (int v = 0; v < 16; v++) begin
            frame_q = {vecs[v].data};
            run_frame($sformatf("sweep%0d", v), vecs[v].odd, vecs[v].par, 0, 1'b0, 0,
                      vecs[v].exp_parity, vecs[v].exp_err, 1'b0, 1);
        end

        frame_q = {4'b1011, 4'b0001, 4'b0110};
        run_frame("tri_even", 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 3);
        run_frame("tri_odd",  1'b1, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 3);

        frame_q = {};
        repeat (10) frame_q.push_back(4'b0001);
        run_frame("ovf10", 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 8);
        frame_q = {};
        repeat (8) frame_q.push_back(4'b0001);
        run_frame("exact8", 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8);

        frame_q = {4'b1011, 4'b0001, 4'b0110};
        run_frame("gap_toggle", 1'b0, 1'b1, 3, 1'b1, 0, 1'b0, 1'b1, 1'b0, 3);
        run_frame("backpressure", 1'b1, 1'b0, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0, 3);

        // Abort a frame with an async reset between clock edges.
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b0001;
        bus.in_last  = 1'b0;
        bus.odd_mode = 1'b0;
        @(posedge clk); #1;
        bus.in_data = 4'b0111;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst in_ready",   32'(bus.in_ready), 1);
        check("arst out_valid",  32'(bus.out_valid), 0);
        check("arst out_parity", 32'(bus.out_parity), 0);
        check("arst par_err",    32'(bus.par_err), 0);
        check("arst len_err",    32'(bus.len_err), 0);
        check("arst out_count",  32'(bus.out_count), 0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        frame_q = {4'b0001};
        run_frame("post_rst", 1'b0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1);

        // Random frames against the reference model.
        for (int f = 0; f < 40; f++) begin
            bit odd, par;
            int n;
            odd = 1'($urandom);
            par = 1'($urandom);
            n   = $urandom_range(11, 1);
            frame_q = {};
            for (int i = 0; i < n; i++) frame_q.push_back(WIDTH'($urandom));
            model(odd, par, ep, ee, el, ec);
            run_frame($sformatf("rand%0d", f), odd, par, 2, 1'b0, $urandom_range(2, 0),
                      ep, ee, el, ec);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
